// File: rtl/bcd_counter.sv
// bcd_counter: presettable multi-digit up/down decimal counter with an
// enable prescaler. Digits are packed BCD, digit 0 in bits [3:0]. bcd_out,
// ovf and step all come straight from flops so the display stage samples
// glitch-free values.
module bcd_counter #(
  parameter int NUM_BCDS = 2,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [NUM_BCDS*4-1:0] load_val,
  output logic [NUM_BCDS*4-1:0] bcd_out,
  output logic                  ovf,
  output logic                  step
);

  // The prescaler is at least one bit wide, even when TICK_DIV is 1.
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PCNT_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         r_pcnt;
  logic [NUM_BCDS*4-1:0] r_bcd;
  logic                  r_ovf;
  logic                  r_step;

  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_BCDS*4-1:0] w_next_bcd;
  logic [NUM_BCDS*4-1:0] w_load_bcd;

  // A count step qualifies on an enabled cycle that completes the prescale.
  assign w_tick = en && (r_pcnt == PCNT_LAST);

  // Ripple the carry or borrow from digit 0 upward. An invalid digit is
  // treated as 9 when counting up and as 0 when counting down.
  always_comb begin
    logic       c;
    logic [3:0] d;
    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    w_next_bcd = '0;
    c          = 1'b1;
    d          = '0;
    for (int i = 0; i < NUM_BCDS; i++) begin
      d = r_bcd[4*i +: 4];
      if (up_dn) begin
        if (d >= 4'd9) begin
          w_next_bcd[4*i +: 4] = c ? 4'd0 : 4'd9;
        end else begin
          w_next_bcd[4*i +: 4] = d + 4'(c);
          c = 1'b0;
        end
      end else begin
        if ((d == 4'd0) || (d > 4'd9)) begin
          w_next_bcd[4*i +: 4] = c ? 4'd9 : 4'd0;
        end else begin
          w_next_bcd[4*i +: 4] = d - 4'(c);
          c = 1'b0;
        end
      end
    end
    w_wrap = c;
  end

  // Sanitise the preset value: any nibble above 9 loads as 0.
  always_comb begin
    w_load_bcd = '0;
    for (int i = 0; i < NUM_BCDS; i++) begin
      w_load_bcd[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end
  end

  // State update with priority clr > load > count step > hold.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      r_pcnt <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_step <= 1'b0;
    end else if (clr) begin
      r_pcnt <= '0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
      r_step <= 1'b0;
    end else if (load) begin
      r_pcnt <= '0;
      r_bcd  <= w_load_bcd;
      r_ovf  <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_tick;
      r_ovf  <= w_tick && w_wrap;
      if (w_tick) begin
        r_bcd <= w_next_bcd;
      end
      if (en) begin
        r_pcnt <= (r_pcnt == PCNT_LAST) ? '0 : r_pcnt + PW'(1);
      end
    end
  end

  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;
  assign step    = r_step;

endmodule

// File: tb/tb_bcd_counter.sv
// Testbench for bcd_counter: three instances (TICK_DIV 1, 4, 3) share the
// stimulus. A decimal-integer reference model predicts every instance.
module tb_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] bcd_a, bcd_b, bcd_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       step_a, step_b, step_c;

  bcd_counter #(.NUM_BCDS(2), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_a), .ovf(ovf_a), .step(step_a));
  bcd_counter #(.NUM_BCDS(2), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_b), .ovf(ovf_b), .step(step_b));
  bcd_counter #(.NUM_BCDS(2), .TICK_DIV(3)) dut_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .bcd_out(bcd_c), .ovf(ovf_c), .step(step_c));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: count held as a plain integer 0..99.
  int m_val[3];
  int m_p[3];
  bit m_ovf[3];
  bit m_step[3];
  int div_of[3] = '{1, 4, 3};

  function automatic int san(input logic [7:0] v);
    int hi, lo;
    hi = (v[7:4] > 4'd9) ? 0 : int'(v[7:4]);
    lo = (v[3:0] > 4'd9) ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_p[k] = 0; m_ovf[k] = 0; m_step[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      m_ovf[k] = 0;
      m_step[k] = 0;
      if (clr) begin
        m_val[k] = 0; m_p[k] = 0;
      end else if (load) begin
        m_val[k] = san(load_val); m_p[k] = 0;
      end else if (en) begin
        if (m_p[k] == div_of[k] - 1) begin
          m_p[k] = 0;
          m_step[k] = 1;
          if (up_dn) begin
            m_ovf[k] = (m_val[k] == 99);
            m_val[k] = (m_val[k] + 1) % 100;
          end else begin
            m_ovf[k] = (m_val[k] == 0);
            m_val[k] = (m_val[k] + 99) % 100;
          end
        end else begin
          m_p[k] = m_p[k] + 1;
        end
      end
    end
  endtask

  task automatic get_dut(input int k, output logic [7:0] b, output logic o, output logic s);
    case (k)
      0:       begin b = bcd_a; o = ovf_a; s = step_a; end
      1:       begin b = bcd_b; o = ovf_b; s = step_b; end
      default: begin b = bcd_c; o = ovf_c; s = step_c; end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [7:0] b;
    logic       o, s;
    for (int k = 0; k < 3; k++) begin
      get_dut(k, b, o, s);
      check($sformatf("%s bcd[%0d]", tag, k), 32'(b), 32'(to_bcd(m_val[k])));
      check($sformatf("%s ovf[%0d]", tag, k), 32'(o), 32'(m_ovf[k]));
      check($sformatf("%s step[%0d]", tag, k), 32'(s), 32'(m_step[k]));
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  // Asynchronous reset pulse placed between edges (called just after an edge).
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, " bcd_a"}, 32'(bcd_a), 32'h0);
    check({tag, " bcd_c"}, 32'(bcd_c), 32'h0);
    check_all(tag);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic       clr;
    logic       load;
    logic       en;
    logic       up_dn;
    logic [7:0] lv;
    logic [7:0] exp_bcd;
    logic       exp_ovf;
    logic       exp_step;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Vectors for the TICK_DIV=1 instance, starting from a count of 10.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h98, 8'h98, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h57, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5C, 8'h50, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h87, 8'h87, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h87, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hF3, 8'h03, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h02, 1'b0, 1'b1};

    model_reset();

    // Reset held low while inputs toggle: everything stays at zero.
    for (int i = 0; i < 4; i++) begin
      en = 1'(i); up_dn = 1'(i >> 1); load = 1'(i); load_val = 8'h57;
      tick();
      check("rst_hold bcd_a", 32'(bcd_a), 32'h0);
      check_all("rst_hold");
    end

    // Release reset and count up from 00 to 10 at one step per clock.
    @(negedge clk);
    load = 1'b0; clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("count_up %0d", i), 32'(bcd_a), 32'({4'(i / 10), 4'(i % 10)}));
      check_all("count_up");
    end

    // Table of wrap, priority and invalid-load cases.
    for (int i = 0; i < 15; i++) begin
      clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
      up_dn = vecs[i].up_dn; load_val = vecs[i].lv;
      tick();
      check($sformatf("vec%0d bcd", i), 32'(bcd_a), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d ovf", i), 32'(ovf_a), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d step", i), 32'(step_a), 32'(vecs[i].exp_step));
      check_all($sformatf("vec%0d", i));
    end

    // Prescaler with TICK_DIV=4, including an enable gap mid-prescale.
    clr = 1'b1; load = 1'b0; en = 1'b0; up_dn = 1'b1;
    tick();
    check_all("pre_clr");
    clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("pre c%0d bcd_b", i), 32'(bcd_b), (i == 4) ? 32'h01 : 32'h00);
      check($sformatf("pre c%0d step_b", i), 32'(step_b), (i == 4) ? 32'h1 : 32'h0);
      check_all("pre");
    end
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pre_gap bcd_b", 32'(bcd_b), 32'h01);
      check_all("pre_gap");
    end
    en = 1'b1;
    tick();
    check("pre_resume1 step_b", 32'(step_b), 32'h0);
    tick();
    check("pre_resume2 bcd_b", 32'(bcd_b), 32'h02);
    check("pre_resume2 step_b", 32'(step_b), 32'h1);
    check_all("pre_resume");

    // Asynchronous reset mid-prescale on the TICK_DIV=3 instance.
    en = 1'b0; load = 1'b1; load_val = 8'h42;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick();
    check("mid bcd_c", 32'(bcd_c), 32'h42);
    en = 1'b0;
    async_reset("mid_rst");
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("post_rst c%0d bcd_c", i), 32'(bcd_c), (i == 3) ? 32'h01 : 32'h00);
      check($sformatf("post_rst c%0d step_c", i), 32'(step_c), (i == 3) ? 32'h1 : 32'h0);
      check_all("post_rst");
    end

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 7) != 0) ? up_dn : ~up_dn;
      load_val = 8'($urandom);
      tick();
      check_all($sformatf("rand%0d", i));
      if ($urandom_range(0, 49) == 0) async_reset($sformatf("rand_rst%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
